// File: rtl/alu_logic_pkg.sv
// ---------------------------------------------------------------------------
// alu_logic_pkg
//
// Shared definitions for the bitwise logic unit of the ALU datapath.
//
// Contents:
//   OP_W        width of the operation code field
//   logic_op_e  the eight bitwise operations, encoded as they appear on in_op
// ---------------------------------------------------------------------------
package alu_logic_pkg;

  localparam int OP_W = 3;

  // Operation codes as presented on in_op.  ANDN clears the bits of x that
  // are set in y.  PASS forwards x untouched.
  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } logic_op_e;

endpackage : alu_logic_pkg

// File: rtl/word_bitop.sv
// ---------------------------------------------------------------------------
// word_bitop
//
// Purely combinational W-bit bitwise operator.  It takes two operand words
// and one of the eight logic_op_e operations and produces the result word.
//
// Parameters:
//   W   operand/result width in bits (W >= 1)
//
// Ports:
//   x   in  W      operand x
//   y   in  W      operand y (ignored for PASS)
//   op  in  OP_W   operation code, interpreted as logic_op_e
//   z   out W      result word
// ---------------------------------------------------------------------------
module word_bitop
  import alu_logic_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    y,
  input  logic [OP_W-1:0] op,
  output logic [W-1:0]    z
);

  // Operation select.  Every encoding is covered.  The default arm only
  // keeps the block free of latches and behaves like PASS.
  always_comb begin
    z = x;
    case (logic_op_e'(op))
      OP_AND:  z = x & y;
      OP_OR:   z = x | y;
      OP_XOR:  z = x ^ y;
      OP_NAND: z = ~(x & y);
      OP_NOR:  z = ~(x | y);
      OP_XNOR: z = ~(x ^ y);
      OP_ANDN: z = x & ~y;
      OP_PASS: z = x;
      default: z = x;
    endcase
  end

endmodule : word_bitop

// File: rtl/word_logic_pipe.sv
// ---------------------------------------------------------------------------
// word_logic_pipe
//
// Two-stage pipelined bitwise logic unit with valid/ready flow control, an
// accumulate mode and per-result flags.
//
// Stage A latches the operands.  The result is formed combinationally from
// stage A and registered into stage B together with its flags.  acc_q tracks
// the result of the most recent transaction to enter stage B.  In accumulate
// mode that value replaces y.
//
// Parameters:
//   W           operand/result width in bits (W >= 1)
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   in_valid    in   1   input transaction present
//   in_ready    out  1   stage A can accept this cycle
//   in_x        in   W   operand x
//   in_y        in   W   operand y (ignored when in_acc = 1)
//   in_op       in   3   operation code (logic_op_e)
//   in_acc      in   1   use accumulator as y operand
//   acc_clr     in   1   synchronous accumulator clear
//   out_valid   out  1   result present
//   out_ready   in   1   downstream accepts result
//   out_z       out  W   result word
//   out_zero    out  1   out_z == 0
//   out_parity  out  1   XOR reduction of out_z
//   out_ones    out  1   out_z is all ones
// ---------------------------------------------------------------------------
module word_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [2:0]   in_op,
  input  logic         in_acc,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
  output logic         out_zero,
  output logic         out_parity,
  output logic         out_ones
);

  // Stage A contents
  logic            a_valid;
  logic [W-1:0]    a_x;
  logic [W-1:0]    a_y;
  logic [OP_W-1:0] a_op;
  logic            a_acc;

  // Accumulator: result of the last transaction that entered stage B
  logic [W-1:0]    acc_q;

  // Handshake and datapath nets
  logic            b_free;
  logic            a_load;
  logic            a_to_b;
  logic [W-1:0]    y_eff;
  logic [W-1:0]    z_next;

  // Stage B can take a new result when it is empty, or when its current
  // result leaves on this same edge.  Stage A can accept when it is empty,
  // or when it empties into B on this edge.
  always_comb begin
    b_free   = !out_valid || out_ready;
    in_ready = !a_valid || b_free;
    a_load   = in_valid && in_ready;
    a_to_b   = a_valid && b_free;
  end

  // Effective y operand.  A clear that coincides with the transfer of an
  // accumulate-mode op must already be seen by that op, so the clear is
  // folded in here instead of waiting for acc_q to drop on the edge.
  always_comb begin
    y_eff = a_y;
    if (a_acc) begin
      y_eff = acc_clr ? '0 : acc_q;
    end
  end

  word_bitop #(
    .W (W)
  ) u_bitop (
    .x  (a_x),
    .y  (y_eff),
    .op (a_op),
    .z  (z_next)
  );

  // Stage A register.  A load takes priority over the drain because both
  // can happen on one edge: the old beat moves to B and a new one arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_x     <= '0;
      a_y     <= '0;
      a_op    <= '0;
      a_acc   <= 1'b0;
    end else if (a_load) begin
      a_valid <= 1'b1;
      a_x     <= in_x;
      a_y     <= in_y;
      a_op    <= in_op;
      a_acc   <= in_acc;
    end else if (a_to_b) begin
      a_valid <= 1'b0;
    end
  end

  // Stage B register.  The result and flags change only when a new beat
  // arrives, so they stay frozen during a stall.  When the last result is
  // taken and nothing replaces it, only the valid bit drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
      out_ones   <= 1'b0;
    end else if (a_to_b) begin
      out_valid  <= 1'b1;
      out_z      <= z_next;
      out_zero   <= (z_next == '0);
      out_parity <= ^z_next;
      out_ones   <= &z_next;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Accumulator.  Every transfer reloads it, whether or not the op used
  // accumulate mode.  A transfer on the same edge as a clear wins, because
  // that op has already consumed the cleared value through y_eff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (a_to_b) begin
      acc_q <= z_next;
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end

endmodule : word_logic_pipe

// File: tb/tb_word_logic_pipe.sv
// ---------------------------------------------------------------------------
// tb_word_logic_pipe
//
// Self-checking bench for word_logic_pipe at W = 16.  Each scenario task
// drives directed vectors and compares the outputs against expected values
// computed by hand or by a small reference model.
// ---------------------------------------------------------------------------
module tb_word_logic_pipe;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic [2:0]   in_op;
  logic         in_acc;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic         out_zero;
  logic         out_parity;
  logic         out_ones;

  int checks = 0;
  int errors = 0;

  word_logic_pipe #(
    .W (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_op      (in_op),
    .in_acc     (in_acc),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .out_ones   (out_ones)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.  Outputs are sampled there
  // and new inputs are driven from there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference bitwise operation
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic [2:0]   op);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x;
    endcase
  endfunction

  task automatic drive_beat(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [2:0] op, input logic acc);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_op    = op;
    in_acc   = acc;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc_clr   = 1'b0;
    step();
    step();
    step();
  endtask

  // Reset state, then a reset that lands with two beats in flight
  task automatic test_reset();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_z !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_z: got %h expected 0000", out_z); end
    checks++;
    if ({out_zero, out_parity, out_ones} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {out_zero, out_parity, out_ones}); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end

    rst_n = 1'b1;
    step();
    drive_beat(16'h1111, 16'h2222, 3'd1, 1'b0);
    step();
    drive_beat(16'h3333, 16'h0F0F, 3'd2, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid: got %b expected 1", out_valid); end

    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_z !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_out_z: got %h expected 0000", out_z); end
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_output cycle %0d: got out_valid %b expected 0", i, out_valid); end
    end
  endtask

  // All eight operations on x = F0F0, y = FF00
  task automatic test_all_ops();
    logic [W-1:0] exp_z [8];
    exp_z = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF,
              16'h000F, 16'hF00F, 16'h00F0, 16'hF0F0};
    drain();
    for (int op = 0; op < 8; op++) begin
      drive_beat(16'hF0F0, 16'hFF00, op[2:0], 1'b0);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL op%0d_latency: got out_valid %b expected 0", op, out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL op%0d_valid: got %b expected 1", op, out_valid); end
      checks++;
      if (out_z !== exp_z[op]) begin errors++; $display("[TB] FAIL op%0d_z: got %h expected %h", op, out_z, exp_z[op]); end
      checks++;
      if ({out_zero, out_parity, out_ones} !== 3'b000) begin errors++; $display("[TB] FAIL op%0d_flags: got %b expected 000", op, {out_zero, out_parity, out_ones}); end
    end
  endtask

  // 100 back-to-back random beats with a reference model and accumulator
  task automatic test_streaming();
    logic [W-1:0] exp_z [100];
    logic [W-1:0] model_acc;
    logic [W-1:0] x, y;
    logic [2:0]   op;
    logic         acc;
    logic         want_valid;
    drain();
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    model_acc = '0;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        x   = W'($urandom);
        y   = W'($urandom);
        op  = 3'($urandom_range(0, 7));
        acc = 1'($urandom_range(0, 1));
        exp_z[i]  = ref_op(x, acc ? model_acc : y, op);
        model_acc = exp_z[i];
        drive_beat(x, y, op, acc);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready beat %0d: got %b expected 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      step();
      want_valid = (i >= 1) && (i <= 100);
      checks++;
      if (out_valid !== want_valid) begin errors++; $display("[TB] FAIL stream_valid cycle %0d: got %b expected %b", i, out_valid, want_valid); end
      if (want_valid) begin
        checks++;
        if (out_z !== exp_z[i-1]) begin errors++; $display("[TB] FAIL stream_z beat %0d: got %h expected %h", i - 1, out_z, exp_z[i-1]); end
        checks++;
        if ({out_zero, out_parity, out_ones} !== {exp_z[i-1] == '0, ^exp_z[i-1], &exp_z[i-1]}) begin
          errors++;
          $display("[TB] FAIL stream_flags beat %0d: got %b expected %b", i - 1, {out_zero, out_parity, out_ones}, {exp_z[i-1] == '0, ^exp_z[i-1], &exp_z[i-1]});
        end
      end
    end
  endtask

  // Stall with out_ready low: only two beats fit, the output holds steady,
  // and release drains exactly those two in order.
  task automatic test_backpressure();
    logic [W-1:0] bx [3];
    logic [W-1:0] got [4];
    int k;
    int accepted;
    int ngot;
    logic take;
    bx = '{16'h1234, 16'h00FF, 16'hABCD};
    drain();
    out_ready = 1'b0;
    k = 0;
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      drive_beat(bx[k], 16'h0F0F, 3'd2, 1'b0);
      take = in_ready;
      step();
      if (take) begin
        accepted++;
        k++;
      end
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_z !== 16'h1D3B) begin
          errors++;
          $display("[TB] FAIL stall_hold cycle %0d: got valid %b z %h expected valid 1 z 1d3b", c, out_valid, out_z);
        end
      end
    end
    checks++;
    if (accepted !== 2) begin errors++; $display("[TB] FAIL stall_accepted: got %0d expected 2", accepted); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b expected 0", in_ready); end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) begin
        got[ngot] = out_z;
        ngot++;
      end
      step();
    end
    checks++;
    if (ngot !== 2) begin errors++; $display("[TB] FAIL release_count: got %0d expected 2", ngot); end
    checks++;
    if (got[0] !== 16'h1D3B) begin errors++; $display("[TB] FAIL release_first: got %h expected 1d3b", got[0]); end
    checks++;
    if (got[1] !== 16'h0FF0) begin errors++; $display("[TB] FAIL release_second: got %h expected 0ff0", got[1]); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_idle: got out_valid %b expected 0", out_valid); end
  endtask

  // Accumulate chain: OR in 1, 2, 4 then XOR with 7 back to zero
  task automatic test_acc_chain();
    logic [W-1:0] xs    [4];
    logic [2:0]   ops   [4];
    logic [W-1:0] exp_z [4];
    logic         exp_zero [4];
    xs       = '{16'h0001, 16'h0002, 16'h0004, 16'h0007};
    ops      = '{3'd1, 3'd1, 3'd1, 3'd2};
    exp_z    = '{16'h0001, 16'h0003, 16'h0007, 16'h0000};
    exp_zero = '{1'b0, 1'b0, 1'b0, 1'b1};
    drain();
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_beat(xs[i], 16'hFFFF, ops[i], 1'b1);
      else       in_valid = 1'b0;
      step();
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_z !== exp_z[i-1]) begin
          errors++;
          $display("[TB] FAIL acc_chain_z step %0d: got valid %b z %h expected valid 1 z %h", i - 1, out_valid, out_z, exp_z[i-1]);
        end
        checks++;
        if (out_zero !== exp_zero[i-1]) begin errors++; $display("[TB] FAIL acc_chain_zero step %0d: got %b expected %b", i - 1, out_zero, exp_zero[i-1]); end
      end
    end
  endtask

  // Clear on the same edge as an accumulate-mode transfer
  task automatic test_clear_collision();
    drain();
    drive_beat(16'h00FF, 16'h0000, 3'd7, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_z !== 16'h00FF) begin errors++; $display("[TB] FAIL collide_setup: got %h expected 00ff", out_z); end
    step();

    drive_beat(16'h1200, 16'h0000, 3'd1, 1'b1);
    step();
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    step();
    acc_clr  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_z !== 16'h1200) begin
      errors++;
      $display("[TB] FAIL collide_result: got valid %b z %h expected valid 1 z 1200", out_valid, out_z);
    end
    step();

    drive_beat(16'h0000, 16'h0000, 3'd1, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_z !== 16'h1200) begin
      errors++;
      $display("[TB] FAIL collide_acc_after: got valid %b z %h expected valid 1 z 1200", out_valid, out_z);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_op     = '0;
    in_acc    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    test_reset();
    test_all_ops();
    test_streaming();
    test_backpressure();
    test_acc_chain();
    test_clear_collision();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_word_logic_pipe

// File: doc/word_logic_pipe.md
# word_logic_pipe

Parametrised, two-stage pipelined bitwise logic unit for the ALU datapath. It generalises the fixed 16-bit AND/OR/XOR word gates to any width W and eight selectable operations. It adds valid/ready flow control, an accumulate mode that chains the previous result in as the y operand, and per-result flags. It sits between operand fetch and the ALU result mux.

## Interface
- W, 16, operand/result width in bits, W >= 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction present
- in_ready  out  1  stage A can accept this cycle
- in_x  in  W  operand x
- in_y  in  W  operand y (ignored when in_acc=1)
- in_op  in  3  operation code (alu_logic_pkg::logic_op_e)
- in_acc  in  1  use accumulator as y operand
- acc_clr  in  1  synchronous accumulator clear
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_z  out  W  result word
- out_zero  out  1  out_z == 0
- out_parity  out  1  XOR-reduction of out_z
- out_ones  out  1  out_z all ones

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (x & ~y), 7 PASS (z = x).
- Stage A stores x, y, op and acc when in_valid && in_ready.
- The result is computed combinationally from stage A contents. On the A->B transfer, the result and all three flags are registered into stage B.
- Effective y = acc_q if the stored acc bit = 1, else the stored y.
- acc_q loads the computed result on every A->B transfer, whether or not acc mode was used. acc_q therefore always holds the result of the most recent transaction to enter stage B. Transfers are strictly in order, so no hazard or forwarding is needed.
- acc_clr = 1 forces acc_q to 0 at the clock edge.
- acc_clr and an A->B transfer in the same cycle: the transferring op sees y = 0 if it is in acc mode. acc_q is then loaded with that op's result, so the transfer wins for the final value.
- Flags are computed from the registered-to-be result, never from out_z combinationally downstream.

## Timing
- Reset (rst_n low, async): stage A and B valid bits = 0; out_z, out_zero, out_parity, out_ones = 0; acc_q = 0.
- A transaction in flight during reset is discarded. No output is produced for it.
- in_ready = !a_valid || b_free, where b_free = !out_valid || out_ready. It is combinational and reads 1 immediately after reset.
- A->B transfer occurs when a_valid && b_free. The stage A valid bit is then refilled or cleared in the same edge.
- Latency: a beat accepted at edge N has out_valid = 1 after edge N+1.
- Throughput: one beat per cycle with out_ready held high.
- Stall: while out_valid && !out_ready, out_z and all flags hold stable. Stage A then fills, and in_ready drops to 0 once stage A is occupied.
- A stall never alters acc_q, because no transfer occurs during a stall.
- out_valid deasserts one edge after the last result is taken, unless a new result is transferred on that edge.

## Structure
- Package alu_logic_pkg:
  - logic_op_e: 3-bit enum with the eight opcodes above.
  - Localparam OP_W = 3.
- Sub-module word_bitop #(W): purely combinational (x, y, op) -> z. Instantiated once, fed by stage A and the acc mux.
- The top level holds both pipeline registers, acc_q and the handshake logic.

## Test plan
- **Reset/idle:** assert rst_n low mid-stream with 2 beats in flight -> out_valid = 0, out_z = 0, in_ready = 1 after release, no stale output.
- **All ops, W=16:** x = 16'hF0F0, y = 16'hFF00, ops 0..7 -> out_z = F000, FFF0, 0FF0, 0FFF, 000F, F00F, 00F0, F0F0. Flags: out_parity = 0 for every result; out_zero = 0 and out_ones = 0 throughout.
- **Streaming:** 100 back-to-back random beats with out_ready = 1 -> one result per cycle, 2-cycle latency, order preserved, matches reference model.
- **Backpressure:** out_ready = 0 for 5 cycles with in_valid = 1 -> exactly 2 beats accepted, in_ready = 0 afterwards, out_z stable. Release -> no loss or duplication.
- **Accumulate chain:** acc_clr, then OR acc with x = 0001, 0002, 0004 -> results 0001, 0003, 0007. A following XOR acc with x = 0007 -> 0000, with out_zero = 1.
- **Clear collision:** acc_q = 00FF, then acc_clr concurrent with the transfer of OR acc x = 1200 -> result 1200, and acc_q = 1200 after.
